matmul_seq: RTL

Host-side sequencer for the matrix-multiply subsystem. It accepts a single valid/ready input stream carrying X then Y (row-major, VECTOR_SIZE×VECTOR_SIZE words each) and writes them into the X and Y BRAMs. It then pulses start to the matmul engine, waits for the engine's done, and streams Z back out of the Z BRAM over a valid/ready output with full backpressure support. It sits between the host/DMA interface and the matmul/BRAM top level, and runs one job at a time, back-to-back.

---
 rtl/matmul_seq_if.sv | 11 +
 rtl/matmul_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_if.sv
// Valid/ready word stream used for the X/Y load path and the Z result path of matmul_seq.
interface matmul_seq_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/matmul_seq.sv
// Host-side sequencer: loads X/Y BRAMs from one stream, kicks the matmul engine, drains Z.
// Optional compute-cycle counter enabled by defining MATMUL_SEQ_PERF_EN.
module matmul_seq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned VECTOR_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    matmul_seq_if.slave           xy_stream,
    matmul_seq_if.master          z_stream,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic                  x_wr_en,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic                  y_wr_en,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic                  busy,
    output logic                  job_done
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]           compute_cycles
`endif
);
    localparam int unsigned N  = VECTOR_SIZE * VECTOR_SIZE;
    localparam int unsigned CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_X  = 3'd1,
        LOAD_Y  = 3'd2,
        START   = 3'd3,
        COMPUTE = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    state_t                state;
    logic [CW-1:0]         ld_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [CW-1:0]         pop_cnt;
    logic                  done_q;
    logic                  inflight;
    logic [1:0]            occ;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [DATA_WIDTH-1:0] fifo [2];

    logic                  hs;
    logic                  pop;
    logic                  issue;
    logic [2:0]            pending;

    // Stream handshakes and BRAM write port decode
    assign xy_stream.ready = (state == LOAD_X) || (state == LOAD_Y);
    assign hs              = xy_stream.valid && xy_stream.ready;
    assign x_wr_en         = xy_stream.valid && (state == LOAD_X);
    assign y_wr_en         = xy_stream.valid && (state == LOAD_Y);
    assign x_din           = xy_stream.data;
    assign y_din           = xy_stream.data;
    assign x_wr_addr       = ld_cnt[ADDR_WIDTH-1:0];
    assign y_wr_addr       = ld_cnt[ADDR_WIDTH-1:0];

    assign z_stream.valid  = (occ != 2'd0);
    assign z_stream.data   = fifo[rd_ptr];
    assign pop             = z_stream.valid && z_stream.ready;

    // A read may only launch if its word is guaranteed a FIFO slot when it lands
    assign pending   = 3'(occ) + 3'(inflight);
    assign issue     = (state == DRAIN) && (rd_cnt < CW'(N)) && (pending < (3'd2 + 3'(pop)));
    assign z_rd_addr = (state == DRAIN) ? rd_cnt[ADDR_WIDTH-1:0] : '0;

    assign mm_start  = (state == START);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ld_cnt   <= '0;
            rd_cnt   <= '0;
            pop_cnt  <= '0;
            done_q   <= 1'b0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            job_done <= 1'b0;
        end else begin
            done_q   <= mm_done;
            job_done <= 1'b0;
            inflight <= issue;
            occ      <= occ + 2'(inflight) - 2'(pop);
            if (inflight) begin
                fifo[wr_ptr] <= z_dout;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case (state)
                IDLE: begin
                    ld_cnt  <= '0;
                    rd_cnt  <= '0;
                    pop_cnt <= '0;
                    state   <= LOAD_X;
                end
                LOAD_X, LOAD_Y: begin
                    if (hs) begin
                        if (ld_cnt == CW'(N - 1)) begin
                            ld_cnt <= '0;
                            state  <= (state == LOAD_X) ? LOAD_Y : START;
                        end else begin
                            ld_cnt <= ld_cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    // Only a fresh rising edge counts; a level left over from the last job is ignored
                    if (mm_done && !done_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        rd_cnt <= rd_cnt + CW'(1);
                    end
                    if (pop) begin
                        if (pop_cnt == CW'(N - 1)) begin
                            state    <= IDLE;
                            job_done <= 1'b1;
                        end else begin
                            pop_cnt <= pop_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    // Engine latency: cleared at START, saturating count of COMPUTE cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compute_cycles <= '0;
        end else if (state == START) begin
            compute_cycles <= '0;
        end else if ((state == COMPUTE) && (compute_cycles != 32'hFFFF_FFFF)) begin
            compute_cycles <= compute_cycles + 32'd1;
        end
    end
`endif

endmodule
